icache_refill_ctrl: RTL and testbench

- Miss handler for the 2-way instruction cache. It is the write-side initiator that drives the replacement block's `instr_write_start`/`write`/`idx` inputs.
- On a fetch miss it requests the line from main memory and collects the word beats. It streams each beat into the cache data/tag arrays.
- It optionally refills the sequential next line (idx+1) when a fetch straddles two lines and both miss.

---
 rtl/icache_refill_ctrl_pkg.sv | 20 ++
 rtl/icache_refill_ctrl_if.sv | 41 ++++
 rtl/icache_refill_ctrl.sv | 111 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and geometry constants for the instruction-cache refill controller.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORDS      = 4;
  localparam int IDX_SIZE   = 6;
  localparam int LINE_BYTES = WORDS * DATA_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int WORD_IDX_W = $clog2(WORDS);
  localparam int TAG_W      = ADDR_W - IDX_SIZE - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-miss, memory read and cache-array write signals of the refill controller.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WORDS    = 4,
  parameter int idx_size = 6
);
  localparam int OFF_W      = $clog2(WORDS * DATA_W / 8);
  localparam int WORD_IDX_W = $clog2(WORDS);
  localparam int TAG_W      = ADDR_W - idx_size - OFF_W;

  logic                  miss_i;
  logic                  miss_next_i;
  logic [ADDR_W-1:0]     miss_addr_i;
  logic                  mem_req_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_valid_i;
  logic [DATA_W-1:0]     mem_rdata_i;
  logic                  instr_write_start_o;
  logic                  write_o;
  logic [idx_size-1:0]   idx_o;
  logic [TAG_W-1:0]      tag_o;
  logic [WORD_IDX_W-1:0] word_off_o;
  logic [DATA_W-1:0]     wdata_o;
  logic                  refill_done_o;
  logic                  busy_o;

  modport master (
    input  miss_i, miss_next_i, miss_addr_i, mem_gnt_i, mem_valid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, instr_write_start_o, write_o, idx_o, tag_o,
           word_off_o, wdata_o, refill_done_o, busy_o
  );

  modport slave (
    output miss_i, miss_next_i, miss_addr_i, mem_gnt_i, mem_valid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, instr_write_start_o, write_o, idx_o, tag_o,
           word_off_o, wdata_o, refill_done_o, busy_o
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: fetches a line (and optionally the next one)
// from memory and streams its beats into the cache data/tag arrays.
//
// state | meaning
// IDLE  | waiting for a fetch miss; line address captured on miss
// REQ   | line read request held until memory grants it
// BEAT  | collecting data beats, one array write per valid beat
// DONE  | line complete; chain to the next line if it also missed
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W   = icache_pkg::ADDR_W,
  parameter int DATA_W   = icache_pkg::DATA_W,
  parameter int WORDS    = icache_pkg::WORDS,
  parameter int idx_size = icache_pkg::IDX_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  icache_refill_ctrl_if.master bus
);

  localparam int L_LINE_BYTES = WORDS * DATA_W / 8;
  localparam int L_OFF_W      = $clog2(L_LINE_BYTES);
  localparam int L_WORD_IDX_W = $clog2(WORDS);
  localparam int L_TAG_W      = ADDR_W - idx_size - L_OFF_W;

  localparam logic [ADDR_W-1:0]       LINE_INC  = ADDR_W'(L_LINE_BYTES);
  localparam logic [ADDR_W-1:0]       OFF_MASK  = ADDR_W'(L_LINE_BYTES - 1);
  localparam logic [L_WORD_IDX_W-1:0] LAST_BEAT = L_WORD_IDX_W'(WORDS - 1);

  refill_state_e           state_q, state_d;
  logic [L_WORD_IDX_W-1:0] beat_cnt_q;
  logic [ADDR_W-1:0]       line_addr_q;
  logic                    pending_next_q;
  logic                    beat_fire;
  logic                    line_out;

  assign beat_fire = (state_q == BEAT) && bus.mem_valid_i;
  assign line_out  = (state_q == BEAT) || (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    bus.mem_req_o           = 1'b0;
    bus.mem_addr_o          = '0;
    bus.write_o             = 1'b0;
    bus.instr_write_start_o = 1'b0;
    bus.word_off_o          = '0;
    bus.wdata_o             = '0;
    bus.refill_done_o       = 1'b0;
    bus.busy_o              = (state_q != IDLE);
    bus.idx_o               = '0;
    bus.tag_o               = '0;

    if (line_out) begin
      bus.idx_o = line_addr_q[L_OFF_W +: idx_size];
      bus.tag_o = line_addr_q[ADDR_W-1 -: L_TAG_W];
    end

    unique case (state_q)
      IDLE: if (bus.miss_i) state_d = REQ;
      REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = line_addr_q;
        if (bus.mem_gnt_i) state_d = BEAT;
      end
      BEAT: begin
        if (beat_fire) begin
          bus.write_o             = 1'b1;
          bus.instr_write_start_o = (beat_cnt_q == '0);
          bus.word_off_o          = beat_cnt_q;
          bus.wdata_o             = bus.mem_rdata_i;
          if (beat_cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        bus.refill_done_o = 1'b1;
        state_d           = pending_next_q ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-line address uses full-width wrap so idx 63 rolls into tag+1 and the top line wraps to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q     <= '0;
      line_addr_q    <= '0;
      pending_next_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.miss_i) begin
          line_addr_q    <= bus.miss_addr_i & ~OFF_MASK;
          pending_next_q <= bus.miss_next_i;
        end
        REQ:  if (bus.mem_gnt_i) beat_cnt_q <= '0;
        BEAT: if (beat_fire) beat_cnt_q <= beat_cnt_q + 1'b1;
        DONE: if (pending_next_q) begin
          line_addr_q    <= line_addr_q + LINE_INC;
          pending_next_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: per-cycle vector table plus hand-built
// sequences for delayed grant, beat gaps, busy-time misses and mid-burst reset.
module tb_icache_refill_ctrl;

  typedef struct packed {
    logic        miss;
    logic        nxt;
    logic [31:0] addr;
    logic        gnt;
    logic        valid;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [31:0] maddr;
    logic        wr;
    logic        start;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic        done;
    logic        busy;
    logic [5:0]  idx;
    logic [21:0] tag;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .idx_size(6)) bus ();

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .idx_size(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic in_t i_none();
    in_t v = '0;
    return v;
  endfunction

  function automatic in_t i_miss(logic [31:0] a, logic m, logic n);
    in_t v = '0;
    v.miss = m; v.nxt = n; v.addr = a;
    return v;
  endfunction

  function automatic in_t i_gnt();
    in_t v = '0;
    v.gnt = 1'b1;
    return v;
  endfunction

  function automatic in_t i_beat(logic [31:0] d);
    in_t v = '0;
    v.valid = 1'b1; v.rdata = d;
    return v;
  endfunction

  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_req(logic [31:0] a);
    out_t o = '0;
    o.req = 1'b1; o.maddr = a; o.busy = 1'b1;
    return o;
  endfunction

  // Byte offset is 4 bits for a 16-byte line, index the next 6, tag the top 22.
  function automatic out_t o_wait(logic [31:0] a);
    out_t o = '0;
    o.busy = 1'b1; o.idx = a[9:4]; o.tag = a[31:10];
    return o;
  endfunction

  function automatic out_t o_beat(logic [31:0] a, int w, logic [31:0] d);
    out_t o = o_wait(a);
    o.wr = 1'b1; o.start = (w == 0); o.off = 2'(w); o.wdata = d;
    return o;
  endfunction

  function automatic out_t o_done(logic [31:0] a);
    out_t o = o_wait(a);
    o.done = 1'b1;
    return o;
  endfunction

  task automatic add(input in_t vi, input out_t vo);
    vec_t v;
    v.i = vi; v.o = vo;
    tbl.push_back(v);
  endtask

  task automatic add_line(input logic [31:0] a, input logic [31:0] d0);
    for (int w = 0; w < 4; w++) add(i_beat(d0 + 32'(w)), o_beat(a, w, d0 + 32'(w)));
  endtask

  task automatic drive(input in_t vi);
    bus.miss_i      = vi.miss;
    bus.miss_next_i = vi.nxt;
    bus.miss_addr_i = vi.addr;
    bus.mem_gnt_i   = vi.gnt;
    bus.mem_valid_i = vi.valid;
    bus.mem_rdata_i = vi.rdata;
  endtask

  task automatic check(input out_t ve, input string nm);
    out_t act;
    act.req   = bus.mem_req_o;
    act.maddr = bus.mem_addr_o;
    act.wr    = bus.write_o;
    act.start = bus.instr_write_start_o;
    act.off   = bus.word_off_o;
    act.wdata = bus.wdata_o;
    act.done  = bus.refill_done_o;
    act.busy  = bus.busy_o;
    act.idx   = bus.idx_o;
    act.tag   = bus.tag_o;
    n_checks++;
    if (act !== ve) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (req,addr,wr,start,off,wdata,done,busy,idx,tag)",
               nm, act, ve);
    end
  endtask

  task automatic apply_check(input in_t vi, input out_t ve, input string nm);
    @(posedge clk);
    #1;
    drive(vi);
    @(negedge clk);
    check(ve, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t vi;
    drive(i_none());
    #2;
    check(o_idle(), "reset_outputs");
    #10 rst_n = 1'b1;

    // IDLE ignores a lone next-line miss and stray beats
    add(i_none(), o_idle());
    add(i_miss(32'h0000_0500, 1'b0, 1'b1), o_idle());
    add(i_beat(32'hDEAD_BEEF), o_idle());
    add(i_none(), o_idle());

    // single miss; a miss during DONE is ignored
    add(i_miss(32'h0000_1234, 1'b1, 1'b0), o_idle());
    add(i_gnt(), o_req(32'h0000_1230));
    add_line(32'h0000_1230, 32'hA000_0000);
    add(i_miss(32'h0000_5000, 1'b1, 1'b1), o_done(32'h0000_1230));
    add(i_none(), o_idle());
    add(i_none(), o_idle());

    // straddle from idx 63 into idx 0 of the next tag
    add(i_miss(32'h0000_03F8, 1'b1, 1'b1), o_idle());
    add(i_gnt(), o_req(32'h0000_03F0));
    add_line(32'h0000_03F0, 32'hB000_0000);
    add(i_none(), o_done(32'h0000_03F0));
    add(i_gnt(), o_req(32'h0000_0400));
    add_line(32'h0000_0400, 32'hB100_0000);
    add(i_none(), o_done(32'h0000_0400));
    add(i_none(), o_idle());

    // top of address space wraps to line 0
    add(i_miss(32'hFFFF_FFF4, 1'b1, 1'b1), o_idle());
    add(i_gnt(), o_req(32'hFFFF_FFF0));
    add_line(32'hFFFF_FFF0, 32'hC000_0000);
    add(i_none(), o_done(32'hFFFF_FFF0));
    add(i_gnt(), o_req(32'h0000_0000));
    add_line(32'h0000_0000, 32'hC100_0000);
    add(i_none(), o_done(32'h0000_0000));
    add(i_none(), o_idle());

    for (int k = 0; k < tbl.size(); k++)
      apply_check(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    // delayed grant and gapped beats
    apply_check(i_miss(32'h0000_5678, 1'b1, 1'b0), o_idle(), "gap_miss");
    for (int c = 0; c < 3; c++) apply_check(i_none(), o_req(32'h0000_5670), $sformatf("gap_req_hold%0d", c));
    apply_check(i_gnt(), o_req(32'h0000_5670), "gap_req_gnt");
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 2; g++)
        apply_check(i_none(), o_wait(32'h0000_5670), $sformatf("gap_idle_b%0d_%0d", b, g));
      apply_check(i_beat(32'hD000_0000 + 32'(b)), o_beat(32'h0000_5670, b, 32'hD000_0000 + 32'(b)),
                  $sformatf("gap_beat%0d", b));
    end
    apply_check(i_none(), o_done(32'h0000_5670), "gap_done");
    apply_check(i_none(), o_idle(), "gap_idle");

    // miss while collecting beats is ignored
    apply_check(i_miss(32'h0000_0100, 1'b1, 1'b0), o_idle(), "busy_miss");
    apply_check(i_gnt(), o_req(32'h0000_0100), "busy_req");
    apply_check(i_beat(32'hE000_0000), o_beat(32'h0000_0100, 0, 32'hE000_0000), "busy_beat0");
    vi = i_beat(32'hE000_0001);
    vi.miss = 1'b1; vi.nxt = 1'b1; vi.addr = 32'h0000_2000;
    apply_check(vi, o_beat(32'h0000_0100, 1, 32'hE000_0001), "busy_beat1_miss");
    apply_check(i_beat(32'hE000_0002), o_beat(32'h0000_0100, 2, 32'hE000_0002), "busy_beat2");
    apply_check(i_beat(32'hE000_0003), o_beat(32'h0000_0100, 3, 32'hE000_0003), "busy_beat3");
    apply_check(i_none(), o_done(32'h0000_0100), "busy_done");
    apply_check(i_none(), o_idle(), "busy_no_req0");
    apply_check(i_none(), o_idle(), "busy_no_req1");

    // asynchronous reset mid-burst, then a clean refill
    apply_check(i_miss(32'h0000_0040, 1'b1, 1'b1), o_idle(), "rst_miss");
    apply_check(i_gnt(), o_req(32'h0000_0040), "rst_req");
    apply_check(i_beat(32'hF000_0000), o_beat(32'h0000_0040, 0, 32'hF000_0000), "rst_beat0");
    apply_check(i_beat(32'hF000_0001), o_beat(32'h0000_0040, 1, 32'hF000_0001), "rst_beat1");
    @(posedge clk);
    #1;
    drive(i_beat(32'hF000_0002));
    #2 rst_n = 1'b0;
    #1 check(o_idle(), "rst_async_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    apply_check(i_beat(32'hF000_0002), o_idle(), "rst_stray_beat2");
    apply_check(i_beat(32'hF000_0003), o_idle(), "rst_stray_beat3");
    apply_check(i_none(), o_idle(), "rst_no_next_line");
    apply_check(i_miss(32'h0000_0080, 1'b1, 1'b0), o_idle(), "rst_new_miss");
    apply_check(i_gnt(), o_req(32'h0000_0080), "rst_new_req");
    for (int w = 0; w < 4; w++)
      apply_check(i_beat(32'h9000_0000 + 32'(w)), o_beat(32'h0000_0080, w, 32'h9000_0000 + 32'(w)),
                  $sformatf("rst_new_beat%0d", w));
    apply_check(i_none(), o_done(32'h0000_0080), "rst_new_done");
    apply_check(i_none(), o_idle(), "rst_new_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
